tsc_sample_ctrl: RTL and testbench
==================================

# tsc_sample_ctrl

Sampling controller for the TSC. It sits directly upstream of the ADC model and drives its `req`/`rst` lines. It consumes `rdy`/`dat` and keeps a pre/post-trigger history of samples in a ring buffer. It timestamps the first sample above a programmable threshold, then hands the captured window to a byte-serial readout port.

## Interface
- `BUF_DEPTH`, 32: ring buffer entries; power of two, at least 4.
- `POST_SAMPLES`, 16: samples captured after the trigger sample; must be less than `BUF_DEPTH`.
- `TS_WIDTH`, 32: timestamp counter width.
- `REQ_TIMEOUT`, 255: maximum clocks allowed for either handshake phase.
- `clk` in 1: single system clock; all state on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse that arms a capture; ignored unless the block is IDLE.
- `stop` in 1: one-cycle pulse that ends capture early.
- `trig_thresh` in 8: trigger fires when a sample is strictly greater than this value.
- `adc_req` out 1: ADC request line.
- `adc_rst` out 1: ADC reset line, active-high.
- `adc_rdy` in 1: ADC ready line; asynchronous to `clk`.
- `adc_dat` in 8: ADC sample; stable while `adc_rdy` is high.
- `busy` out 1: high in every state except IDLE.
- `triggered` out 1: sticky; set at the trigger sample, cleared by `start`.
- `done` out 1: high while in DONE or READ.
- `timestamp` out `TS_WIDTH`: counter value latched at the trigger sample.
- `rd_en` in 1: readout request, one byte per asserted cycle.
- `rd_data` out 8: readout byte.
- `rd_valid` out 1: `rd_data` is valid this cycle.
- `rd_last` out 1: qualifies the final byte of the window.
- `err_timeout` out 1: sticky handshake-timeout flag; cleared by `start`.

## Operation
- Reset value of every output is 0.
- States: IDLE, ARST, REQ, REL, DONE, READ.
- **IDLE:** `start` clears the flags, buffer pointer, fill count and timestamp counter, then goes to ARST.
- **ARST:** `adc_rst`=1 for exactly 1 clock, then REQ.
- **REQ:** `adc_req`=1. When the synchronised ready (`rdy_s`) rises:
  - write `adc_dat` at `wr_ptr`;
  - `wr_ptr` increments modulo `BUF_DEPTH`;
  - `fill` saturates at `BUF_DEPTH`;
  - go to REL.
- **Trigger:** evaluated on each sample written.
  - If not yet triggered and sample > `trig_thresh`: set `triggered`, latch the counter into `timestamp`, set `post_cnt` to `POST_SAMPLES`.
  - If already triggered: decrement `post_cnt`.
- **REL:** `adc_req`=0; wait for `rdy_s`=0. Then:
  - go to DONE if triggered and `post_cnt`=0, or if `stop` is pending;
  - otherwise go back to REQ.
- **`stop`:** a pulse in REQ or REL is latched and acts at the next REL exit, so the current handshake always completes. A pulse in IDLE is ignored.
- **Timeout:** a wait counter is cleared on entry to REQ or REL. If it reaches `REQ_TIMEOUT`:
  - drive `adc_req`=0;
  - pulse `adc_rst` for 2 clocks;
  - set `err_timeout`;
  - go to IDLE with `done`=0.
- **DONE:** `rd_en` moves to READ with `rd_ptr` = `wr_ptr` − `fill` (mod `BUF_DEPTH`), which is the oldest sample.
- **READ:**
  - each `rd_en` cycle outputs one byte the next clock and increments `rd_ptr`;
  - `rd_last` is set on byte `fill`;
  - after that byte the block goes to IDLE;
  - `rd_en` low leaves the block paused in READ.
- **Timestamp counter:** free-running from ARST; wraps modulo 2^`TS_WIDTH`.
- **`rst_n` low mid-handshake:** all outputs drop to 0 immediately. Buffer contents are don't-care.

## Timing
- **Synchroniser:** `adc_rdy` passes through a 2-flop synchroniser; the block acts on edges of `rdy_s` only.
- **Capture latency:** a sample is written on the first clock `rdy_s`=1, which is 2 clocks after `adc_rdy` rises.
- **Fastest sample period:** 1 ARST clock (first sample only), then REQ ≥3 clocks plus REL ≥3 clocks.
- **Readout latency:** `rd_data`, `rd_valid` and `rd_last` are registered, 1 clock after `rd_en`.
- **Simultaneous `start` and `stop` in IDLE:** `start` wins and `stop` is discarded.
- **Trigger on the last sample before `stop`:** `triggered` and `timestamp` stay valid. The post window is truncated and `fill` reflects what was actually written.

## Structure
- **Shared package:** `tsc_pkg` holds the state enum `tsc_state_t`, `SAMPLE_W`=8 and the default parameter constants.
- **Sub-module:** `tsc_ring_buf`, a single-write/single-read RAM with pointer wrap logic. The controller FSM, synchroniser, counters and flags live in `tsc_sample_ctrl`.

## Test plan
- **Basic trigger:** ADC ramp 0x00..0xFF, `trig_thresh`=0x40, defaults.
  - Trigger on 0x41 with `timestamp` matching the capture clock.
  - Readout of 32 bytes 0x32..0x51, `rd_last` on 0x51.
- **Early stop:** `stop` after 5 samples, never triggered.
  - `done`=1, `triggered`=0.
  - Readout is exactly 5 bytes 0x00..0x04.
- **Wrap:** trigger at sample 100.
  - Readout starts 15 samples before the trigger sample and is 32 bytes long.
  - Byte 16 is the trigger sample.
- **Timeout:** hold `adc_rdy` at 0.
  - `adc_req` drops after 255 clocks and `adc_rst` pulses for 2 clocks.
  - `err_timeout`=1, state returns to IDLE.
  - `err_timeout` clears on the next `start`.
- **Async reset mid-handshake:** `rst_n` low in REQ; all outputs are 0 within the same clock.
- **Paused readout:** gaps in `rd_en` during readout give no skipped or duplicated bytes.

Source files
------------

// File: rtl/tsc_pkg.sv
// Shared types and default constants for the TSC sampling controller.
package tsc_pkg;

  localparam int SAMPLE_W         = 8;
  localparam int DEF_BUF_DEPTH    = 32;
  localparam int DEF_POST_SAMPLES = 16;
  localparam int DEF_TS_WIDTH     = 32;
  localparam int DEF_REQ_TIMEOUT  = 255;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARST,
    ST_REQ,
    ST_REL,
    ST_DONE,
    ST_READ
  } tsc_state_t;

endpackage

// File: rtl/tsc_ring_buf.sv
// Sample ring buffer: one write port, one registered read port, wrapping pointers.
module tsc_ring_buf
  import tsc_pkg::*;
#(
  parameter int DEPTH = DEF_BUF_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                wr_en,
  input  logic [SAMPLE_W-1:0] wr_data,
  input  logic                rd_start,
  input  logic [AW-1:0]       rd_back,
  input  logic                rd_en,
  output logic [SAMPLE_W-1:0] rd_data
);

  logic [SAMPLE_W-1:0] mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two; a full buffer
  // has rd_back == 0, so the oldest entry is the one at wr_ptr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_data <= '0;
    end else begin
      if (clear)      wr_ptr <= '0;
      else if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_start) begin
        rd_ptr <= wr_ptr - rd_back;
      end else if (rd_en) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tsc_sample_ctrl.sv
// TSC sampling controller: ADC handshake FSM, trigger/timestamp capture and
// byte-serial readout of the pre/post-trigger window.
module tsc_sample_ctrl
  import tsc_pkg::*;
#(
  parameter int BUF_DEPTH    = DEF_BUF_DEPTH,
  parameter int POST_SAMPLES = DEF_POST_SAMPLES,
  parameter int TS_WIDTH     = DEF_TS_WIDTH,
  parameter int REQ_TIMEOUT  = DEF_REQ_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stop,
  input  logic [7:0]          trig_thresh,
  output logic                adc_req,
  output logic                adc_rst,
  input  logic                adc_rdy,
  input  logic [7:0]          adc_dat,
  output logic                busy,
  output logic                triggered,
  output logic                done,
  output logic [TS_WIDTH-1:0] timestamp,
  input  logic                rd_en,
  output logic [7:0]          rd_data,
  output logic                rd_valid,
  output logic                rd_last,
  output logic                err_timeout
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int FW = AW + 1;
  localparam int PW = $clog2(POST_SAMPLES + 1);
  localparam int WW = $clog2(REQ_TIMEOUT + 1);

  tsc_state_t          state, state_nxt;
  logic                rdy_m, rdy_s;
  logic [WW-1:0]       wait_cnt;
  logic [PW-1:0]       post_cnt;
  logic [FW-1:0]       fill;
  logic [FW-1:0]       rd_cnt;
  logic                stop_pend;
  logic [1:0]          tout_cnt;
  logic [TS_WIDTH-1:0] ts_cnt;
  logic                tout;
  logic                wr_en, rd_start, rd_fetch, clear, wait_hit, is_last;

  assign wr_en    = (state == ST_REQ) && rdy_s;
  assign rd_start = (state == ST_DONE) && rd_en;
  assign rd_fetch = (state == ST_READ) && rd_en;
  assign clear    = (state == ST_IDLE) && start;
  assign wait_hit = (wait_cnt == WW'(REQ_TIMEOUT - 1));
  assign is_last  = (rd_cnt == fill - 1'b1);

  // The rd_en seen in DONE only positions the read pointer; bytes flow from READ.
  always_comb begin
    state_nxt = state;
    tout      = 1'b0;
    busy      = (state != ST_IDLE);
    done      = (state == ST_DONE) || (state == ST_READ);
    adc_req   = (state == ST_REQ);
    adc_rst   = (state == ST_ARST) || (tout_cnt != 2'd0);
    case (state)
      ST_IDLE: if (start) state_nxt = ST_ARST;
      ST_ARST: state_nxt = ST_REQ;
      ST_REQ: begin
        if (rdy_s) begin
          state_nxt = ST_REL;
        end else if (wait_hit) begin
          state_nxt = ST_IDLE;
          tout      = 1'b1;
        end
      end
      ST_REL: begin
        if (!rdy_s) begin
          if ((triggered && post_cnt == '0) || stop_pend || stop) state_nxt = ST_DONE;
          else                                                   state_nxt = ST_REQ;
        end else if (wait_hit) begin
          state_nxt = ST_IDLE;
          tout      = 1'b1;
        end
      end
      ST_DONE: if (rd_en) state_nxt = ST_READ;
      ST_READ: if (rd_en && is_last) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      rdy_m       <= 1'b0;
      rdy_s       <= 1'b0;
      wait_cnt    <= '0;
      post_cnt    <= '0;
      fill        <= '0;
      rd_cnt      <= '0;
      stop_pend   <= 1'b0;
      tout_cnt    <= 2'd0;
      ts_cnt      <= '0;
      triggered   <= 1'b0;
      timestamp   <= '0;
      err_timeout <= 1'b0;
      rd_valid    <= 1'b0;
      rd_last     <= 1'b0;
    end else begin
      state <= state_nxt;
      rdy_m <= adc_rdy;
      rdy_s <= rdy_m;

      if (state_nxt != state)                     wait_cnt <= '0;
      else if (state == ST_REQ || state == ST_REL) wait_cnt <= wait_cnt + 1'b1;

      if (clear)                 ts_cnt <= '0;
      else if (state != ST_IDLE) ts_cnt <= ts_cnt + 1'b1;

      if (tout)                  tout_cnt <= 2'd2;
      else if (tout_cnt != 2'd0) tout_cnt <= tout_cnt - 1'b1;

      if (clear) begin
        triggered   <= 1'b0;
        timestamp   <= '0;
        err_timeout <= 1'b0;
        stop_pend   <= 1'b0;
        fill        <= '0;
        post_cnt    <= '0;
      end else begin
        if (tout) err_timeout <= 1'b1;
        if (stop && (state == ST_ARST || state == ST_REQ || state == ST_REL))
          stop_pend <= 1'b1;
        if (wr_en) begin
          if (fill != FW'(BUF_DEPTH)) fill <= fill + 1'b1;
          if (!triggered && adc_dat > trig_thresh) begin
            triggered <= 1'b1;
            timestamp <= ts_cnt;
            post_cnt  <= PW'(POST_SAMPLES);
          end else if (triggered && post_cnt != '0) begin
            post_cnt <= post_cnt - 1'b1;
          end
        end
      end

      if (rd_start)      rd_cnt <= '0;
      else if (rd_fetch) rd_cnt <= rd_cnt + 1'b1;
      rd_valid <= rd_fetch;
      rd_last  <= rd_fetch && is_last;
    end
  end

  tsc_ring_buf #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .wr_en    (wr_en),
    .wr_data  (adc_dat),
    .rd_start (rd_start),
    .rd_back  (fill[AW-1:0]),
    .rd_en    (rd_fetch),
    .rd_data  (rd_data)
  );

endmodule

// File: tb/tb_tsc_sample_ctrl.sv
// Randomised scoreboard bench for tsc_sample_ctrl with a behavioural ADC and
// a window reference model computed from the delivered sample list.
module tb_tsc_sample_ctrl;

  localparam int DEPTH = 32;
  localparam int POST  = 16;
  localparam int NSRC  = 512;

  logic        clk, rst_n, start, stop, adc_req, adc_rst, adc_rdy;
  logic [7:0]  trig_thresh, adc_dat, rd_data;
  logic        busy, triggered, done, rd_en, rd_valid, rd_last, err_timeout;
  logic [31:0] timestamp;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } exp_t;
  exp_t exp_q[$];

  logic [7:0] src [NSRC];
  int         raise_cyc [NSRC];
  int         stop_after = 0;
  int         run_id = 0;
  bit         adc_en = 0;
  int         start_c = 0;

  tsc_sample_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .trig_thresh (trig_thresh),
    .adc_req     (adc_req),
    .adc_rst     (adc_rst),
    .adc_rdy     (adc_rdy),
    .adc_dat     (adc_dat),
    .busy        (busy),
    .triggered   (triggered),
    .done        (done),
    .timestamp   (timestamp),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_last     (rd_last),
    .err_timeout (err_timeout)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h want=0x%0h", name, act, want);
    end
  endtask

  // ADC model: answers adc_req after a random delay, holds data until req drops,
  // and optionally pulses stop while delivering the chosen sample.
  initial begin : adc_model
    int phase, dly, n_deliv, last_run;
    phase = 0; dly = 0; n_deliv = 0; last_run = 0;
    adc_rdy = 0; adc_dat = 0; stop = 0;
    forever begin
      @(negedge clk);
      stop = 0;
      if (run_id != last_run) begin
        last_run = run_id;
        n_deliv  = 0;
      end
      if (!adc_en) begin
        adc_rdy = 0;
        phase   = 0;
      end else if (phase == 0) begin
        if (adc_req && n_deliv < NSRC) begin
          if (dly > 0) dly--;
          else begin
            adc_dat = src[n_deliv];
            adc_rdy = 1;
            raise_cyc[n_deliv] = cyc;
            if (n_deliv + 1 == stop_after) stop = 1;
            n_deliv++;
            phase = 1;
            dly   = $urandom_range(0, 3);
          end
        end
      end else if (!adc_req) begin
        if (dly > 0) dly--;
        else begin
          adc_rdy = 0;
          phase   = 0;
          dly     = $urandom_range(0, 3);
        end
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("rd_extra_byte", 32'(rd_data), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          checkOutput("rd_data", 32'(rd_data), 32'(e.d));
          checkOutput("rd_last", 32'(rd_last), 32'(e.l));
        end
      end
    end
  end

  task automatic pulseStart();
    @(negedge clk);
    start   = 1;
    start_c = cyc;
    @(negedge clk);
    start = 0;
  endtask

  // Runs one capture and readout; reference derives the window from the rules:
  // end at trigger+POST or at the stop sample, keep the last DEPTH samples.
  task automatic applyStimulus(input logic [7:0] thresh, input int stop_at, input string tag);
    int t, n, first, issued, guard;
    exp_t e;
    trig_thresh = thresh;
    stop_after  = stop_at;
    run_id++;
    adc_en = 1;
    pulseStart();
    guard = 0;
    while (!done && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    if (!done) return;

    t = -1; n = NSRC;
    for (int i = 0; i < NSRC; i++) begin
      if (t < 0 && src[i] > thresh) t = i;
      if (stop_at > 0 && i + 1 == stop_at) begin n = i + 1; break; end
      if (t >= 0 && i == t + POST) begin n = i + 1; break; end
    end
    checkOutput({tag, "_triggered"}, 32'(triggered), 32'(t >= 0));
    if (t >= 0) checkOutput({tag, "_timestamp"}, timestamp, 32'(raise_cyc[t] - start_c + 1));

    first = (n > DEPTH) ? n - DEPTH : 0;
    for (int i = first; i < n; i++) begin
      e.d = src[i];
      e.l = (i == n - 1);
      exp_q.push_back(e);
    end

    rd_en = 1;
    @(negedge clk);
    issued = 0; guard = 0;
    while (issued < n - first && guard < 2000) begin
      rd_en = ($urandom_range(0, 2) != 0);
      if (rd_en) issued++;
      @(negedge clk);
      guard++;
    end
    rd_en = 0;
    repeat (3) @(negedge clk);
    checkOutput({tag, "_rd_remaining"}, 32'(exp_q.size()), 32'd0);
    checkOutput({tag, "_idle_after"}, 32'(busy), 32'd0);
    exp_q.delete();
  endtask

  initial begin : main
    int cnt;
    rst_n = 0; start = 0; rd_en = 0; trig_thresh = 0;
    repeat (3) @(negedge clk);
    checkOutput("rst_flags", 32'({adc_req, adc_rst, busy, triggered, done, rd_valid, rd_last, err_timeout}), 32'd0);
    checkOutput("rst_timestamp", timestamp, 32'd0);
    checkOutput("rst_rd_data", 32'(rd_data), 32'd0);
    rst_n = 1;
    repeat (2) @(negedge clk);

    $display("[TB] basic trigger");
    for (int i = 0; i < NSRC; i++) src[i] = 8'(i);
    applyStimulus(8'h40, 0, "basic");

    $display("[TB] early stop");
    applyStimulus(8'hFF, 5, "stop");

    $display("[TB] wrap");
    for (int i = 0; i < NSRC; i++) src[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 100; i++) src[i] = 8'($urandom_range(0, 8'h80));
    src[100] = 8'($urandom_range(8'h81, 8'hFF));
    applyStimulus(8'h80, 0, "wrap");

    $display("[TB] random runs");
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NSRC; i++) src[i] = 8'($urandom_range(0, 255));
      applyStimulus(8'($urandom_range(8'h20, 8'hE0)), $urandom_range(1, 70), "rand");
    end

    $display("[TB] timeout");
    adc_en = 0;
    run_id++;
    pulseStart();
    cnt = 0;
    while (!adc_req && cnt < 20) begin @(negedge clk); cnt++; end
    cnt = 0;
    while (adc_req && cnt < 1000) begin @(negedge clk); cnt++; end
    checkOutput("tout_req_cycles", 32'(cnt), 32'd255);
    cnt = 0;
    while (adc_rst && cnt < 10) begin @(negedge clk); cnt++; end
    checkOutput("tout_rst_cycles", 32'(cnt), 32'd2);
    checkOutput("tout_err", 32'(err_timeout), 32'd1);
    checkOutput("tout_idle", 32'({busy, done}), 32'd0);
    pulseStart();
    checkOutput("tout_err_cleared", 32'(err_timeout), 32'd0);

    $display("[TB] async reset in REQ");
    cnt = 0;
    while (!adc_req && cnt < 20) begin @(negedge clk); cnt++; end
    checkOutput("pre_rst_in_req", 32'({adc_req, busy}), 32'd3);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    checkOutput("arst_flags", 32'({adc_req, adc_rst, busy, triggered, done, rd_valid, rd_last, err_timeout}), 32'd0);
    checkOutput("arst_timestamp", timestamp, 32'd0);
    @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
